// File: rtl/rc_add_sub_seq.sv
// Multi-cycle ripple-carry adder/subtractor: CHUNK bits per clock, LSB chunk first.
// Optional saturation on signed overflow when RC_ADD_SUB_SAT_EN is defined (adds SAT input).
module rc_add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             SnA,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef RC_ADD_SUB_SAT_EN
  input  logic             SAT,
`endif
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             OV
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IW = $clog2(WIDTH);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             state;
  logic [WIDTH-1:0] aReg;
  logic [WIDTH-1:0] bReg;
  logic             carryReg;
  logic [CW-1:0]    cnt;
`ifdef RC_ADD_SUB_SAT_EN
  logic             satReg;
`endif

  logic [IW-1:0]    offset;
  logic [CHUNK-1:0] aChunk;
  logic [CHUNK-1:0] bChunk;
  logic [CHUNK:0]   chunkSum;
  logic             msbCarryIn;
  logic             lastChunk;

  assign BUSY = (state == STATE_RUN);

  // One chunk of the ripple add; carry into the MSB is recovered from the top sum bit.
  always_comb begin
    offset     = IW'(int'(cnt) * CHUNK);
    aChunk     = aReg[offset +: CHUNK];
    bChunk     = bReg[offset +: CHUNK];
    chunkSum   = {1'b0, aChunk} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carryReg};
    msbCarryIn = aChunk[CHUNK-1] ^ bChunk[CHUNK-1] ^ chunkSum[CHUNK-1];
    lastChunk  = (cnt == CW'(NCHUNK - 1));
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= STATE_IDLE;
      aReg     <= '0;
      bReg     <= '0;
      carryReg <= 1'b0;
      cnt      <= '0;
      DONE     <= 1'b0;
      Y        <= '0;
      CO       <= 1'b0;
      OV       <= 1'b0;
`ifdef RC_ADD_SUB_SAT_EN
      satReg   <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      if (state == STATE_IDLE) begin
        if (START) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with SnA.
          aReg     <= A;
          bReg     <= B ^ {WIDTH{SnA}};
          carryReg <= SnA;
          cnt      <= '0;
          Y        <= '0;
          CO       <= 1'b0;
          OV       <= 1'b0;
          state    <= STATE_RUN;
`ifdef RC_ADD_SUB_SAT_EN
          satReg   <= SAT;
`endif
        end
      end else begin
        Y[offset +: CHUNK] <= chunkSum[CHUNK-1:0];
        carryReg           <= chunkSum[CHUNK];
        cnt                <= cnt + CW'(1);
        if (lastChunk) begin
          CO    <= chunkSum[CHUNK];
          OV    <= msbCarryIn ^ chunkSum[CHUNK];
          DONE  <= 1'b1;
          state <= STATE_IDLE;
`ifdef RC_ADD_SUB_SAT_EN
          if (satReg && (msbCarryIn ^ chunkSum[CHUNK])) begin
            Y <= aReg[WIDTH-1] ? SAT_NEG : SAT_POS;
          end
`endif
        end
      end
    end
  end

endmodule
